// File: rtl/prio_encoder_pkg.sv
// Shared types and helpers for the registered priority encoder / arbiter.
package prio_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Code width for n lines; never below one bit.
    function automatic int clog2w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prio_encoder_arb_pick.sv
// Find-first-set over N bits, scanning upward from a start index with wrap-around.
module prio_pick
    import prio_encoder_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    int unsigned j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            j = unsigned'(32'(start)) + i;
            if (j >= unsigned'(N)) begin
                j = j - unsigned'(N);
            end
            if (!found && vec[j[W-1:0]]) begin
                found = 1'b1;
                idx   = j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered active-low priority encoder with sticky pending bits, per-line mask,
// fixed or round-robin selection, and a grant code held until acknowledged.
module prio_encoder_arb
    import prio_encoder_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    localparam int W      = clog2w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_in_n,
    input  logic [N-1:0] req_n,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         gs_n,
    output logic         en_out_n,
    output logic [N-1:0] pending
);

    localparam logic [W-1:0] LAST_LINE = W'(N - 1);

    state_t       state, state_nx;
    logic [N-1:0] elig;
    logic [N-1:0] set_bits;
    logic [N-1:0] clr;
    logic [W-1:0] last_grant;
    logic [W-1:0] start;
    logic [W-1:0] pick;
    logic         found;
    logic         load;
    logic         accept;

    assign elig     = pending & ~mask;
    assign set_bits = en_in_n ? '0 : (~req_n & ~mask);
    assign accept   = (state == GRANT) && ack;
    assign gs_n     = ~valid;

    // Round-robin resumes one above the last grant; fixed priority always scans from line 0.
    assign start = (RR_MODE != 0)
                 ? ((last_grant == LAST_LINE) ? '0 : last_grant + 1'b1)
                 : '0;

    prio_pick #(.N(N)) u_pick (
        .vec   (elig),
        .start (start),
        .idx   (pick),
        .found (found)
    );

    always_comb begin
        clr = '0;
        if (accept) begin
            clr[code] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (!en_in_n && found) begin
                    state_nx = GRANT;
                    load     = 1'b1;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_nx = GAP;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            code       <= '0;
            valid      <= 1'b0;
            en_out_n   <= 1'b1;
            last_grant <= LAST_LINE;
        end else begin
            state <= state_nx;
            // Set after clear so a re-asserted request survives its own acknowledge.
            pending  <= (pending & ~clr) | set_bits;
            en_out_n <= ~(!en_in_n && (elig == '0) && !valid);
            if (load) begin
                code       <= pick;
                valid      <= 1'b1;
                last_grant <= pick;
            end else if (accept) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Scoreboard bench: stimulus pushes expected grant codes, per-DUT monitors pop and compare.
module tb_prio_encoder_arb;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;

    logic         en0, ack0;
    logic [N-1:0] req0, mask0;
    logic [W-1:0] code0;
    logic         valid0, gs0, eo0;
    logic [N-1:0] pend0;

    logic         enr, ackr;
    logic [N-1:0] reqr, maskr;
    logic [W-1:0] coder;
    logic         validr, gsr, eor;
    logic [N-1:0] pendr;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] qr[$];

    always #5 clk = ~clk;

    prio_encoder_arb #(.N(N), .RR_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .en_in_n(en0), .req_n(req0), .mask(mask0), .ack(ack0),
        .code(code0), .valid(valid0), .gs_n(gs0), .en_out_n(eo0), .pending(pend0)
    );

    prio_encoder_arb #(.N(N), .RR_MODE(1)) dutr (
        .clk(clk), .reset(reset), .en_in_n(enr), .req_n(reqr), .mask(maskr), .ack(ackr),
        .code(coder), .valid(validr), .gs_n(gsr), .en_out_n(eor), .pending(pendr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for a grant on the chosen DUT, acknowledge it for one cycle,
    // then confirm the grant was dropped.
    task automatic ack_next(input bit rr, input int maxc);
        int n;
        n = 0;
        while (!(rr ? validr : valid0) && n < maxc) begin
            tick();
            n++;
        end
        if (!(rr ? validr : valid0)) begin
            fail(rr ? "rr_grant_timeout" : "fx_grant_timeout");
        end else begin
            if (rr) ackr = 1'b1; else ack0 = 1'b1;
            tick();
            ackr = 1'b0;
            ack0 = 1'b0;
            chk(rr ? "rr_gap_valid" : "fx_gap_valid", 32'(rr ? validr : valid0), 32'd0);
        end
    endtask

    logic         prev0 = 1'b0, prevr = 1'b0;
    logic [W-1:0] held0 = '0, heldr = '0;

    always @(negedge clk) begin
        if (valid0 && !prev0) begin
            if (q0.size() == 0) begin
                fail("fx_unexpected_grant");
            end else begin
                chk("fx_grant_code", 32'(code0), 32'(q0.pop_front()));
            end
            held0 = code0;
        end else if (valid0) begin
            chk("fx_hold_code", 32'(code0), 32'(held0));
        end
        prev0 = valid0;
    end

    always @(negedge clk) begin
        if (validr && !prevr) begin
            if (qr.size() == 0) begin
                fail("rr_unexpected_grant");
            end else begin
                chk("rr_grant_code", 32'(coder), 32'(qr.pop_front()));
            end
            heldr = coder;
        end else if (validr) begin
            chk("rr_hold_code", 32'(coder), 32'(heldr));
        end
        prevr = validr;
    end

    initial begin
        reset = 1'b1;
        en0 = 1'b0; ack0 = 1'b0; req0 = '1; mask0 = '0;
        enr = 1'b0; ackr = 1'b0; reqr = '1; maskr = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_gs_n", 32'(gs0), 32'd1);
        chk("rst_en_out_n", 32'(eo0), 32'd1);
        chk("rst_code", 32'(code0), 32'd0);
        chk("rst_pending", 32'(pend0), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_en_out_n", 32'(eo0), 32'd0);
        chk("idle_gs_n", 32'(gs0), 32'd1);
        chk("idle_rr_en_out_n", 32'(eor), 32'd0);

        // Lines 2 and 4 pulsed for a single cycle.
        req0 = 8'b1110_1011;
        q0.push_back(3'd2);
        q0.push_back(3'd4);
        tick();
        req0 = '1;
        chk("lat_pending", 32'(pend0), 32'h14);
        chk("lat_valid_edge1", 32'(valid0), 32'd0);
        tick();
        chk("lat_valid_edge2", 32'(valid0), 32'd1);
        chk("lat_gs_n", 32'(gs0), 32'd0);
        ack_next(0, 8);
        ack_next(0, 8);
        chk("drain_pending", 32'(pend0), 32'd0);
        tick();
        chk("drain_en_out_n", 32'(eo0), 32'd0);

        // Round-robin with lines 1, 3, 6 held low.
        reqr = ~8'b0100_1010;
        for (int i = 0; i < 2; i++) begin
            qr.push_back(3'd1);
            qr.push_back(3'd3);
            qr.push_back(3'd6);
        end
        for (int i = 0; i < 6; i++) begin
            ack_next(1, 12);
        end
        enr  = 1'b1;
        reqr = '1;
        tick();
        tick();
        chk("rr_frozen_valid", 32'(validr), 32'd0);

        // Masked pending line: kept but not granted until unmasked.
        req0  = 8'b1101_1111;
        tick();
        req0  = '1;
        mask0 = 8'b0010_0000;
        for (int i = 0; i < 4; i++) tick();
        chk("mask_no_grant", 32'(valid0), 32'd0);
        chk("mask_pending_kept", 32'(pend0), 32'h20);
        chk("mask_en_out_n", 32'(eo0), 32'd0);
        q0.push_back(3'd5);
        mask0 = '0;
        tick();
        chk("unmask_grant", 32'(valid0), 32'd1);
        en0   = 1'b1;
        req0  = 8'b1111_1110;
        mask0 = '1;
        for (int i = 0; i < 3; i++) tick();
        chk("frozen_valid", 32'(valid0), 32'd1);
        chk("frozen_code", 32'(code0), 32'd5);
        req0  = '1;
        mask0 = '0;
        en0   = 1'b0;
        ack_next(0, 4);
        chk("frozen_no_capture", 32'(pend0), 32'd0);
        tick();
        tick();

        // Acknowledge coinciding with a re-asserted request on the same line.
        req0 = 8'b1111_0111;
        q0.push_back(3'd3);
        tick();
        req0 = '1;
        tick();
        chk("ackset_first_grant", 32'(valid0), 32'd1);
        req0 = 8'b1111_0111;
        ack0 = 1'b1;
        q0.push_back(3'd3);
        tick();
        ack0 = 1'b0;
        req0 = '1;
        chk("ackset_pending", 32'(pend0), 32'h08);
        chk("ackset_gap_valid", 32'(valid0), 32'd0);
        ack_next(0, 8);

        // Reset while a grant is outstanding.
        req0 = 8'b0111_1111;
        q0.push_back(3'd7);
        tick();
        req0 = '1;
        tick();
        chk("rstg_pre_valid", 32'(valid0), 32'd1);
        reset = 1'b1;
        tick();
        chk("rstg_valid", 32'(valid0), 32'd0);
        chk("rstg_gs_n", 32'(gs0), 32'd1);
        chk("rstg_en_out_n", 32'(eo0), 32'd1);
        chk("rstg_code", 32'(code0), 32'd0);
        chk("rstg_pending", 32'(pend0), 32'd0);
        reset = 1'b0;
        tick();
        tick();

        chk("fx_queue_drained", 32'(q0.size()), 32'd0);
        chk("rr_queue_drained", 32'(qr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
